// File: rtl/dma_req_queue.sv
// dma_req_queue: descriptor FIFO that issues one DMA request at a time over the dreq_/eop_ handshake.
// Optional macro DMA_TIMEOUT_EN: abort a request that sees no eop_ within TIMEOUT cycles.
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 32
`endif

module dma_req_queue #(
    parameter int DEPTH   = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       push,
    input  logic [`BUS_ADDR_WIDTH-1:0] push_saddr,
    input  logic [`BUS_ADDR_WIDTH-1:0] push_daddr,
    input  logic [1:0]                 push_mode,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [`BUS_ADDR_WIDTH-1:0] dsaddr,
    output logic [`BUS_ADDR_WIDTH-1:0] ddaddr,
    output logic [1:0]                 dmode,
    output logic                       dreq_,
    input  logic                       eop_,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 dbg_state
);

    // Handshake: push is accepted on any cycle full is low. A request is valid while dreq_ is low
    // with dsaddr/ddaddr/dmode stable; the controller acknowledges with eop_ low for >= 1 cycle,
    // sampled from the cycle after dreq_ falls. The next request waits for eop_ high plus GAP cycles.
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int DW = `BUS_ADDR_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;
    localparam logic [1:0] S_GAPWAIT = 2'd3;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dma_req_queue: DEPTH must be a power of 2 and at least 2");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("dma_req_queue: GAP must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("dma_req_queue: TIMEOUT must be at least 1");
    end

    logic [DW-1:0] saddr_mem [DEPTH];
    logic [DW-1:0] daddr_mem [DEPTH];
    logic [1:0]    mode_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          dreq_q, dreq_d;
    logic          done_q, done_d;
    logic [DW-1:0] saddr_q, daddr_q;
    logic [1:0]    mode_q;
    logic          push_ok, pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign level     = count_q;
    assign push_ok   = push && !full;
    assign dsaddr    = saddr_q;
    assign ddaddr    = daddr_q;
    assign dmode     = mode_q;
    assign dreq_     = dreq_q;
    assign done      = done_q;
    assign busy      = (state_q == S_REQ) || (state_q == S_RELEASE);
    assign dbg_state = state_q;

`ifdef DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        dreq_d  = dreq_q;
        done_d  = 1'b0;
        gap_d   = '0;
        pop     = 1'b0;
`ifdef DMA_TIMEOUT_EN
        tmr_d   = '0;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty && eop_) begin
                    pop     = 1'b1;
                    dreq_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Completion wins over a timeout that expires on the same cycle.
                if (!eop_) begin
                    dreq_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_RELEASE;
                end
`ifdef DMA_TIMEOUT_EN
                else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    dreq_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_GAPWAIT;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
`endif
            end
            S_RELEASE: begin
                if (eop_) begin
                    state_d = S_GAPWAIT;
                end
            end
            S_GAPWAIT: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Descriptor storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            saddr_mem[wr_ptr_q] <= push_saddr;
            daddr_mem[wr_ptr_q] <= push_daddr;
            mode_mem[wr_ptr_q]  <= push_mode;
        end
    end

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            gap_q    <= '0;
            dreq_q   <= 1'b1;
            done_q   <= 1'b0;
            saddr_q  <= '0;
            daddr_q  <= '0;
            mode_q   <= '0;
`ifdef DMA_TIMEOUT_EN
            tmr_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            gap_q   <= gap_d;
            dreq_q  <= dreq_d;
            done_q  <= done_d;
`ifdef DMA_TIMEOUT_EN
            tmr_q   <= tmr_d;
            err_q   <= err_d;
`endif
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                saddr_q  <= saddr_mem[rd_ptr_q];
                daddr_q  <= daddr_mem[rd_ptr_q];
                mode_q   <= mode_mem[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_dma_req_queue.sv
// Bench for dma_req_queue: directed descriptor traffic, a transaction-level reference model
// compared every cycle, and hand-computed expectations for latency, gaps, full and reset.
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 32
`endif

module tb_dma_req_queue;

    localparam int DEPTH   = 4;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 64;
    localparam int DW      = `BUS_ADDR_WIDTH;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk, rst, push, eop_;
    logic [DW-1:0] push_saddr, push_daddr;
    logic [1:0]    push_mode;
    logic          full, empty, busy, done, err, dreq_;
    logic [LW-1:0] level;
    logic [DW-1:0] dsaddr, ddaddr;
    logic [1:0]    dmode, dbg_state;

    int checks   = 0;
    int failures = 0;

    dma_req_queue #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset_     (rst),
        .push       (push),
        .push_saddr (push_saddr),
        .push_daddr (push_daddr),
        .push_mode  (push_mode),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .dsaddr     (dsaddr),
        .ddaddr     (ddaddr),
        .dmode      (dmode),
        .dreq_      (dreq_),
        .eop_       (eop_),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Descriptors live in a queue; requests are tracked as "outstanding", "waiting for eop_ to
    // rise", and an absolute edge number before which no new request may start.
    logic [2*DW+1:0] m_q[$];
    logic            m_active, m_release, m_done, m_err;
    logic [DW-1:0]   m_saddr, m_daddr;
    logic [1:0]      m_mode;
    int              cyc, m_next_issue, m_req_cyc;
    logic            m_can_push, m_do_pop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_active     = 1'b0;
            m_release    = 1'b0;
            m_done       = 1'b0;
            m_err        = 1'b0;
            m_saddr      = '0;
            m_daddr      = '0;
            m_mode       = '0;
            cyc          = 0;
            m_next_issue = 0;
            m_req_cyc    = 0;
        end else begin
            cyc++;
            m_done     = 1'b0;
            m_err      = 1'b0;
            m_do_pop   = 1'b0;
            m_can_push = push && (m_q.size() < DEPTH);
            if (m_active) begin
                if (!eop_) begin
                    m_active  = 1'b0;
                    m_release = 1'b1;
                    m_done    = 1'b1;
                end else begin
                    m_req_cyc++;
`ifdef DMA_TIMEOUT_EN
                    if (m_req_cyc == TIMEOUT) begin
                        m_active     = 1'b0;
                        m_err        = 1'b1;
                        m_next_issue = cyc + GAP + 1;
                    end
`endif
                end
            end else if (m_release) begin
                if (eop_) begin
                    m_release    = 1'b0;
                    m_next_issue = cyc + GAP + 1;
                end
            end else if (cyc >= m_next_issue && m_q.size() > 0 && eop_) begin
                m_do_pop = 1'b1;
            end
            if (m_do_pop) begin
                {m_saddr, m_daddr, m_mode} = m_q.pop_front();
                m_active  = 1'b1;
                m_req_cyc = 0;
            end
            if (m_can_push) begin
                m_q.push_back({push_saddr, push_daddr, push_mode});
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cmp_dreq",   dreq_,  !m_active);
        chk("cmp_busy",   busy,   m_active || m_release);
        chk("cmp_done",   done,   m_done);
        chk("cmp_err",    err,    m_err);
        chk("cmp_level",  level,  m_q.size());
        chk("cmp_full",   full,   m_q.size() == DEPTH);
        chk("cmp_empty",  empty,  m_q.size() == 0);
        chk("cmp_dsaddr", dsaddr, m_saddr);
        chk("cmp_ddaddr", ddaddr, m_daddr);
        chk("cmp_dmode",  dmode,  m_mode);
    end

    // Minimum dreq_-high run between consecutive requests.
    int   high_run;
    logic seen_req;
    always @(negedge clk) begin
        if (rst) begin
            high_run = 0;
            seen_req = 1'b0;
        end else if (dreq_) begin
            high_run++;
        end else begin
            if (seen_req && high_run > 0) begin
                chk("gap_min_high", high_run >= GAP + 1, 1);
            end
            seen_req = 1'b1;
            high_run = 0;
        end
    end

    // ---------------- drivers ----------------
    task automatic push_desc(input logic [DW-1:0] s, input logic [DW-1:0] d, input logic [1:0] m);
        push       = 1'b1;
        push_saddr = s;
        push_daddr = d;
        push_mode  = m;
        tick();
        push       = 1'b0;
    endtask

    task automatic wait_req(input int max, output int waited);
        waited = 0;
        while (dreq_ !== 1'b0 && waited < max) begin
            tick();
            waited++;
        end
    endtask

    // ---------------- directed stimulus ----------------
    logic [DW-1:0] t2_s [3];
    logic [DW-1:0] t2_d [3];
    int            w, k;

    initial begin
        rst        = 1'b1;
        push       = 1'b0;
        push_saddr = '0;
        push_daddr = '0;
        push_mode  = '0;
        eop_       = 1'b1;
        t2_s[0] = 'h150; t2_d[0] = 'h160;
        t2_s[1] = 'h200; t2_d[1] = 'h170;
        t2_s[2] = 'h170; t2_d[2] = 'h220;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_dreq",  dreq_, 1);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_busy",  busy,  0);

        // single descriptor: dreq_ falls two edges after push
        push_desc('h150, 'h160, 2'b01);
        chk("t1_dreq_after_write", dreq_, 1);
        tick();
        chk("t1_dreq_low",  dreq_,  0);
        chk("t1_dsaddr",    dsaddr, 'h150);
        chk("t1_ddaddr",    ddaddr, 'h160);
        chk("t1_dmode",     dmode,  2'b01);
        eop_ = 1'b0;
        tick();
        eop_ = 1'b1;
        chk("t1_done",      done,  1);
        chk("t1_dreq_high", dreq_, 1);
        chk("t1_empty",     empty, 1);
        chk("t1_busy_rel",  busy,  1);
        tick();
        chk("t1_done_pulse", done, 0);
        repeat (6) tick();

        // three back-to-back descriptors, one-cycle eop_ pulses
        for (int i = 0; i < 3; i++) begin
            push_desc(t2_s[i], t2_d[i], 2'(i));
        end
        for (int i = 0; i < 3; i++) begin
            wait_req(40, w);
            chk("t2_req_seen", dreq_, 0);
            if (i > 0) chk("t2_wait_cycles", w, GAP + 2);
            chk("t2_dsaddr", dsaddr, t2_s[i]);
            chk("t2_ddaddr", ddaddr, t2_d[i]);
            eop_ = 1'b0;
            tick();
            eop_ = 1'b1;
            chk("t2_done", done, 1);
        end
        repeat (6) tick();
        chk("t2_final_level", level, 0);
        chk("t2_final_empty", empty, 1);

        // fill past DEPTH while eop_ low blocks issue
        eop_ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_desc(DW'('h1000 + i * 'h10), DW'('h2000 + i * 'h10), 2'(i));
            if (i == 3) begin
                chk("t3_full_after4",  full,  1);
                chk("t3_level_after4", level, 4);
            end
        end
        chk("t3_level_after5", level, 4);
        chk("t3_no_req_eop_low", dreq_, 1);
        eop_ = 1'b1;
        tick();
        chk("t3_dreq_low",  dreq_,  0);
        chk("t3_level_pop", level,  3);
        chk("t3_full_clr",  full,   0);
        chk("t3_dsaddr",    dsaddr, 'h1000);

        // eop_ held low for five cycles
        eop_ = 1'b0;
        tick();
        chk("t4_done",  done,  1);
        chk("t4_dreq",  dreq_, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_done_once",  done,  0);
            chk("t4_busy_held",  busy,  1);
            chk("t4_dreq_held",  dreq_, 1);
        end
        eop_ = 1'b1;
        for (int i = 0; i < GAP + 1; i++) begin
            tick();
            chk("t4_gap_hold", dreq_, 1);
        end
        tick();
        chk("t4_second_req", dreq_,  0);
        chk("t4_dsaddr",     dsaddr, 'h1010);
        chk("t4_level",      level,  2);

        // asynchronous reset while a request is outstanding
        #3 rst = 1'b1;
        #1;
        chk("t5_dreq_async", dreq_, 1);
        chk("t5_level",      level, 0);
        chk("t5_busy",       busy,  0);
        chk("t5_empty",      empty, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) tick();
        chk("t5_no_req", dreq_, 1);
        push_desc('h300, 'h400, 2'b10);
        tick();
        chk("t5_new_req", dreq_,  0);
        chk("t5_dsaddr",  dsaddr, 'h300);
        eop_ = 1'b0;
        tick();
        eop_ = 1'b1;
        chk("t5_done", done, 1);
        repeat (6) tick();

`ifdef DMA_TIMEOUT_EN
        // no eop_: abort after TIMEOUT request cycles, then issue the next descriptor
        push_desc('h500, 'h600, 2'b01);
        push_desc('h510, 'h610, 2'b10);
        wait_req(10, w);
        chk("t6_req_seen", dreq_,  0);
        chk("t6_dsaddr",   dsaddr, 'h500);
        k = 0;
        while (dreq_ === 1'b0 && k < 100) begin
            tick();
            k++;
        end
        chk("t6_timeout_cycles", k,    TIMEOUT);
        chk("t6_err",            err,  1);
        chk("t6_no_done",        done, 0);
        tick();
        chk("t6_err_pulse", err, 0);
        wait_req(10, w);
        chk("t6_next_wait",   w,      2);
        chk("t6_next_req",    dreq_,  0);
        chk("t6_next_dsaddr", dsaddr, 'h510);
        eop_ = 1'b0;
        tick();
        eop_ = 1'b1;
        chk("t6_next_done", done, 1);
        repeat (6) tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog simulation did not complete at t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_req_queue.md
Name: dma_req_queue

Overview:
- Requester-side partner of the DMA controller's dreq_/eop_ handshake.
- Holds a small FIFO of transfer descriptors (source address, destination address, mode), pushed by the processor or peripheral logic.
- Issues them one at a time to the DMA controller by driving dsaddr/ddaddr/dmode and asserting dreq_ until the controller signals end-of-transfer on eop_.
- Sits between the descriptor producers and the DMA controller inside top.

Parameters:
- DEPTH, 4, number of descriptor FIFO entries (power of 2, minimum 2).
- GAP, 2, minimum idle cycles with dreq_ deasserted between consecutive requests (minimum 1).
- TIMEOUT, 64, cycles to wait for eop_ before aborting a request (used only with DMA_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- reset_  in  1  reset; asynchronous and active-high.
- push  in  1  write descriptor into FIFO this cycle.
- push_saddr  in  `BUS_ADDR_WIDTH  descriptor source address.
- push_daddr  in  `BUS_ADDR_WIDTH  descriptor destination address.
- push_mode  in  2  descriptor dmode (SingleM2M/BurstM2M/BurstIO2M/BurstM2IO encodings, passed through unchanged).
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(DEPTH)+1  current entry count.
- dsaddr  out  `BUS_ADDR_WIDTH  source address to DMA controller.
- ddaddr  out  `BUS_ADDR_WIDTH  destination address to DMA controller.
- dmode  out  2  transfer mode to DMA controller.
- dreq_  out  1  DMA request, active-low.
- eop_  in  1  end of transfer from DMA controller, active-low.
- busy  out  1  a request is outstanding (REQ or RELEASE state).
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse on timeout abort (tied 0 without DMA_TIMEOUT_EN).

Behaviour:
- Reset values:
  - dreq_=1; dsaddr=0, ddaddr=0, dmode=0.
  - full=0, empty=1, level=0; busy=0, done=0, err=0.
  - FIFO pointers cleared, state=IDLE.
- Reset mid-transfer: dreq_ returns to 1 immediately (asynchronous); queued descriptors are discarded.
- FIFO:
  - push while full is ignored; level unchanged.
  - Push and pop in the same cycle: level unchanged, both take effect.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, REQ, RELEASE, GAPWAIT.
- IDLE:
  - If !empty and eop_=1: pop the head entry and register it onto dsaddr/ddaddr/dmode.
  - dreq_=0 on the same edge; go to REQ.
  - Latency: push into an empty FIFO produces dreq_ low 2 cycles later (1 cycle for write, 1 cycle for the pop edge).
  - If eop_=0 while in IDLE, no request is issued until eop_ returns to 1.
- REQ:
  - dreq_ held at 0; dsaddr/ddaddr/dmode held stable.
  - On a sampled eop_=0: dreq_=1 on that edge, done pulses 1 cycle, go to RELEASE.
- RELEASE:
  - Wait until eop_=1 (the DMA controller may hold eop_ low for several cycles), then go to GAPWAIT.
- GAPWAIT:
  - Count GAP cycles with dreq_=1, then go to IDLE.
  - Consecutive requests are therefore separated by at least GAP+1 cycles of dreq_=1.
- busy=1 in REQ and RELEASE.
- Pushes are accepted in every state; a descriptor is never popped while busy.
- eop_ edge cases: an eop_ low pulse of exactly one cycle is sufficient. eop_ low on the same edge dreq_ is first asserted is not accepted; eop_ is first sampled the following cycle.

Optional Feature:
- Macro: DMA_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT)+1 clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT without eop_=0: dreq_=1, err pulses 1 cycle, done stays 0, the descriptor is dropped, go to GAPWAIT.
  - eop_=0 on the same cycle the count reaches TIMEOUT counts as completion (done, not err).
- Undefined:
  - No counter; REQ waits indefinitely; err is constant 0.

Test Plan:
- Reset → dreq_=1, empty=1, level=0. Push {0x150, 0x160, BurstM2M} → dreq_=0 2 cycles later with dsaddr=0x150, ddaddr=0x160. Drive eop_=0 one cycle later → done pulse, dreq_=1, empty=1.
- Push 3 descriptors back to back (0x150→0x160, 0x200→0x170, 0x170→0x220), eop_ low 1 cycle after each request → three requests in order, each separated by ≥3 dreq_-high cycles (GAP=2), final level=0.
- Push 5 with DEPTH=4 and no eop_ → full=1 after the 4th push, 5th dropped; 1 popped into REQ, level=3.
- Hold eop_ low for 5 cycles after the first request with a second descriptor queued → second dreq_ appears only GAP+1 cycles after eop_ returns high.
- With DMA_TIMEOUT_EN and TIMEOUT=64: never assert eop_ → dreq_ rises at cycle 64 of REQ, err=1 for 1 cycle, done=0, next descriptor issued afterwards.
- Assert reset_=1 while in REQ → dreq_=1 immediately, level=0, busy=0. After release, no request until a new push.
